guard_recovery_ctrl: RTL and testbench
======================================

# guard_recovery_ctrl

Recovery sequencer for the AXI monitor guards. It collects the latched reset requests from the write guard and the read guard and isolates the monitored subordinate. It then pulses the subordinate reset, waits for software (or automatic) acknowledgement, and finally returns the clear pulse that releases both guards. It sits between the guards' `reset_req_o`/`reset_clear_i` pins, the AXI isolate stage and the subordinate's reset input.

## Interface
- `ResetCycles`, default 16: number of cycles `slv_rst_no` is held low; must be ≥1.
- `IsolateTimeout`, default 256: maximum cycles to wait for `isolated_i`; must be ≥1.
- `CntWidth`, default 16: internal counter width; must hold `max(ResetCycles, IsolateTimeout)`.
- `clk_i`, in, 1: clock.
- `rst_ni`, in, 1: synchronous active-low reset.
- `wr_reset_req_i`, in, 1: latched reset request from the write guard (level).
- `rd_reset_req_i`, in, 1: latched reset request from the read guard (level).
- `isolated_i`, in, 1: isolate stage reports the subordinate is fully isolated.
- `sw_clear_i`, in, 1: software acknowledge, single-cycle strobe from the register file.
- `isolate_o`, out, 1: request isolation of the subordinate.
- `slv_rst_no`, out, 1: active-low reset to the subordinate.
- `reset_clear_o`, out, 1: one-cycle pulse driven to both guards' `reset_clear_i`.
- `busy_o`, out, 1: state is not IDLE.
- `irq_o`, out, 1: one-cycle pulse when a recovery episode starts.
- `cause_o`, out, 2: bit0 = write guard, bit1 = read guard; accumulated over the episode.
- `isolate_timeout_o`, out, 1: isolation was not acknowledged within `IsolateTimeout`.
- `recovery_cnt_o`, out, 8: completed recoveries; saturates at 255.

## Operation
- FSM states: IDLE, ISOLATE, RESET, HOLD, RELEASE. All outputs are registered.
- **IDLE**: if `wr_reset_req_i | rd_reset_req_i`:
  - load `cause_o` with `{rd, wr}` and clear `isolate_timeout_o`;
  - clear the counter and pulse `irq_o`;
  - go to ISOLATE.
- **ISOLATE**: `isolate_o`=1.
  - `isolated_i`=1: load counter with `ResetCycles-1` and go to RESET.
  - Else, counter == `IsolateTimeout-1`: set `isolate_timeout_o`, load counter with `ResetCycles-1` and go to RESET.
  - Else: increment counter.
- **RESET**: `slv_rst_no`=0 and `isolate_o`=1. Counter decrements; at 0, go to HOLD.
- **HOLD**: `slv_rst_no`=1 and `isolate_o`=1. On `sw_clear_i`, go to RELEASE.
- **RELEASE**: `reset_clear_o`=1 and `isolate_o`=1 for exactly one cycle. `recovery_cnt_o` is incremented (saturating). Go to IDLE.
- In ISOLATE, RESET and HOLD, a newly asserted request ORs its bit into `cause_o`. It does not restart the sequence.
- `sw_clear_i` is ignored in every state except HOLD.
- If a guard still holds its request after RELEASE (a new fault, since the guard's set has priority over clear), IDLE starts a new episode on the following cycle.
- `cause_o`, `isolate_timeout_o` and `recovery_cnt_o` hold their values in IDLE until the next episode starts.

## Timing
- Reset (`rst_ni`=0 sampled at an edge, any state): next state is IDLE. Outputs after that edge:
  - `isolate_o`=0, `slv_rst_no`=1, `reset_clear_o`=0, `busy_o`=0, `irq_o`=0;
  - `cause_o`=0, `isolate_timeout_o`=0, `recovery_cnt_o`=0.
- Request sampled at edge k: from k+1, `isolate_o`=1, `busy_o`=1 and `irq_o`=1 (for one cycle).
- `isolated_i` sampled high at edge m: `slv_rst_no`=0 from m+1 for exactly `ResetCycles` cycles.
- `isolated_i` already high on the first ISOLATE cycle: ISOLATE lasts one cycle.
- Timeout path: ISOLATE lasts exactly `IsolateTimeout` cycles.
- `sw_clear_i` sampled in HOLD at edge h:
  - `reset_clear_o`=1 during cycle h+1;
  - `isolate_o`=0 and `busy_o`=0 from h+2.
- Simultaneous `isolated_i` and timeout on the same cycle: take the `isolated_i` path; `isolate_timeout_o` stays 0.

## Configuration
- `GUARD_RECOVERY_AUTO_CLEAR_EN`:
  - Defined: HOLD lasts one cycle, then goes to RELEASE regardless of `sw_clear_i`; `sw_clear_i` is unused.
  - Undefined: HOLD waits indefinitely for `sw_clear_i`.

## Test plan
- **Write-guard fault**: ResetCycles=4, `wr_reset_req_i`=1, `isolated_i` returned 2 cycles after `isolate_o` rises, `sw_clear_i` pulsed in HOLD.
  - Required: `irq_o` single pulse, `cause_o`=01, `slv_rst_no` low for exactly 4 cycles, one `reset_clear_o` pulse, `recovery_cnt_o`=1, `busy_o`=0 two cycles after the clear.
- **Isolation timeout**: IsolateTimeout=8, `isolated_i` stuck at 0.
  - Required: RESET entered after 8 ISOLATE cycles; `isolate_timeout_o`=1 until the next episode starts.
- **Second source mid-episode**: `rd_reset_req_i` rises during RESET of a write episode.
  - Required: `cause_o`=11, no restart, `slv_rst_no` low for exactly ResetCycles.
- **Persistent request**: `wr_reset_req_i` held high through RELEASE.
  - Required: a new episode starts (`irq_o` pulses again) the cycle after IDLE is entered; `recovery_cnt_o` increments per episode and saturates at 255 after 260 episodes.
- **Reset mid-operation**: `rst_ni`=0 during RESET.
  - Required: all outputs at their reset values after the next edge, with `slv_rst_no`=1.
- **Ignored clear / auto-clear**: `sw_clear_i` pulsed in ISOLATE or RESET.
  - Required without `GUARD_RECOVERY_AUTO_CLEAR_EN`: the pulse is ignored, and the FSM stays in HOLD until a later pulse.
  - Required with `GUARD_RECOVERY_AUTO_CLEAR_EN`: `reset_clear_o` asserts 2 cycles after RESET ends, with no `sw_clear_i`.

Source files
------------

// File: rtl/guard_recovery_ctrl.sv
// Recovery sequencer: isolates the subordinate, pulses its reset, waits for acknowledge, then clears the guards.
// Optional GUARD_RECOVERY_AUTO_CLEAR_EN: HOLD self-acknowledges after one cycle instead of waiting for sw_clear_i.
module guard_recovery_ctrl #(
  parameter int unsigned ResetCycles    = 16,
  parameter int unsigned IsolateTimeout = 256,
  parameter int unsigned CntWidth       = 16
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       wr_reset_req_i,
  input  logic       rd_reset_req_i,
  input  logic       isolated_i,
  input  logic       sw_clear_i,
  output logic       isolate_o,
  output logic       slv_rst_no,
  output logic       reset_clear_o,
  output logic       busy_o,
  output logic       irq_o,
  output logic [1:0] cause_o,
  output logic       isolate_timeout_o,
  output logic [7:0] recovery_cnt_o
);

  typedef enum logic [2:0] {
    IDLE,
    ISOLATE,
    RESET,
    HOLD,
    RELEASE
  } state_e;

  state_e              state_q, state_d;
  logic [CntWidth-1:0] cnt_q, cnt_d;
  logic                isolate_q, isolate_d;
  logic                slv_rst_n_q, slv_rst_n_d;
  logic                reset_clear_q, reset_clear_d;
  logic                busy_q, busy_d;
  logic                irq_q, irq_d;
  logic [1:0]          cause_q, cause_d;
  logic                timeout_q, timeout_d;
  logic [7:0]          rcnt_q, rcnt_d;
  logic                ack;

`ifdef GUARD_RECOVERY_AUTO_CLEAR_EN
  logic unused_sw_clear;
  assign unused_sw_clear = sw_clear_i;
  assign ack = 1'b1;
`else
  assign ack = sw_clear_i;
`endif

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    cause_d   = cause_q;
    timeout_d = timeout_q;
    rcnt_d    = rcnt_q;
    irq_d     = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (wr_reset_req_i | rd_reset_req_i) begin
          cause_d   = {rd_reset_req_i, wr_reset_req_i};
          timeout_d = 1'b0;
          cnt_d     = '0;
          irq_d     = 1'b1;
          state_d   = ISOLATE;
        end
      end
      ISOLATE: begin
        cause_d = cause_q | {rd_reset_req_i, wr_reset_req_i};
        // isolated_i wins over a timeout landing on the same cycle
        if (isolated_i) begin
          cnt_d   = CntWidth'(ResetCycles - 1);
          state_d = RESET;
        end else if (cnt_q == CntWidth'(IsolateTimeout - 1)) begin
          timeout_d = 1'b1;
          cnt_d     = CntWidth'(ResetCycles - 1);
          state_d   = RESET;
        end else begin
          cnt_d = cnt_q + CntWidth'(1);
        end
      end
      RESET: begin
        cause_d = cause_q | {rd_reset_req_i, wr_reset_req_i};
        if (cnt_q == '0) begin
          state_d = HOLD;
        end else begin
          cnt_d = cnt_q - CntWidth'(1);
        end
      end
      HOLD: begin
        cause_d = cause_q | {rd_reset_req_i, wr_reset_req_i};
        if (ack) begin
          state_d = RELEASE;
        end
      end
      RELEASE: begin
        if (rcnt_q != 8'hFF) begin
          rcnt_d = rcnt_q + 8'd1;
        end
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // Outputs are registered, so they are decoded from the next state
    busy_d        = (state_d != IDLE);
    isolate_d     = (state_d != IDLE);
    slv_rst_n_d   = (state_d != RESET);
    reset_clear_d = (state_d == RELEASE);
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q       <= IDLE;
      cnt_q         <= '0;
      isolate_q     <= 1'b0;
      slv_rst_n_q   <= 1'b1;
      reset_clear_q <= 1'b0;
      busy_q        <= 1'b0;
      irq_q         <= 1'b0;
      cause_q       <= '0;
      timeout_q     <= 1'b0;
      rcnt_q        <= '0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      isolate_q     <= isolate_d;
      slv_rst_n_q   <= slv_rst_n_d;
      reset_clear_q <= reset_clear_d;
      busy_q        <= busy_d;
      irq_q         <= irq_d;
      cause_q       <= cause_d;
      timeout_q     <= timeout_d;
      rcnt_q        <= rcnt_d;
    end
  end

  assign isolate_o         = isolate_q;
  assign slv_rst_no        = slv_rst_n_q;
  assign reset_clear_o     = reset_clear_q;
  assign busy_o            = busy_q;
  assign irq_o             = irq_q;
  assign cause_o           = cause_q;
  assign isolate_timeout_o = timeout_q;
  assign recovery_cnt_o    = rcnt_q;

endmodule

// File: tb/tb_guard_recovery_ctrl.sv
// Directed bench for guard_recovery_ctrl with ResetCycles=4, IsolateTimeout=8.
module tb_guard_recovery_ctrl;

  localparam int unsigned RC = 4;
  localparam int unsigned IT = 8;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       wr_req, rd_req, iso_in, sw_clr;
  logic       isolate, slv_rst_n, reset_clear, busy, irq, timeout;
  logic [1:0] cause;
  logic [7:0] rcnt;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  guard_recovery_ctrl #(
    .ResetCycles   (RC),
    .IsolateTimeout(IT),
    .CntWidth      (16)
  ) dut (
    .clk_i            (clk),
    .rst_ni           (rst_n),
    .wr_reset_req_i   (wr_req),
    .rd_reset_req_i   (rd_req),
    .isolated_i       (iso_in),
    .sw_clear_i       (sw_clr),
    .isolate_o        (isolate),
    .slv_rst_no       (slv_rst_n),
    .reset_clear_o    (reset_clear),
    .busy_o           (busy),
    .irq_o            (irq),
    .cause_o          (cause),
    .isolate_timeout_o(timeout),
    .recovery_cnt_o   (rcnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int unsigned obs, input int unsigned exp);
    n_checks++;
    if (obs != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Counts cycles with slv_rst_no low; returns in HOLD.
  task automatic count_reset(output int unsigned n, output logic irq_seen);
    n = 0;
    irq_seen = 1'b0;
    while (slv_rst_n == 1'b0 && n < 50) begin
      irq_seen |= irq;
      n++;
      step();
    end
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_isolate"}, isolate, 0);
    check({tag, "_slv_rst_n"}, slv_rst_n, 1);
    check({tag, "_reset_clear"}, reset_clear, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_irq"}, irq, 0);
    check({tag, "_cause"}, cause, 0);
    check({tag, "_timeout"}, timeout, 0);
    check({tag, "_rcnt"}, rcnt, 0);
  endtask

  initial begin
    int unsigned n;
    logic        seen;

    rst_n = 1'b0; wr_req = 1'b0; rd_req = 1'b0; iso_in = 1'b0; sw_clr = 1'b0;
    step(); step();
    check_reset_values("por");
    rst_n = 1'b1;
    step();
    check("idle_busy", busy, 0);

    // Write-guard fault, isolation acknowledged two cycles after isolate_o rises
    wr_req = 1'b1;
    step();
    wr_req = 1'b0;
    check("t1_irq", irq, 1);
    check("t1_isolate", isolate, 1);
    check("t1_busy", busy, 1);
    check("t1_cause", cause, 1);
    step();
    check("t1_irq_single", irq, 0);
    check("t1_still_isolating", slv_rst_n, 1);
    iso_in = 1'b1;
    step();
    check("t1_rst_low", slv_rst_n, 0);
    count_reset(n, seen);
    check("t1_rst_cycles", n, RC);
    iso_in = 1'b0;
    check("t1_hold_busy", busy, 1);
    check("t1_hold_clear", reset_clear, 0);
    sw_clr = 1'b1;
    step();
    sw_clr = 1'b0;
    check("t1_clear_pulse", reset_clear, 1);
    check("t1_release_iso", isolate, 1);
    step();
    check("t1_clear_single", reset_clear, 0);
    check("t1_busy_off", busy, 0);
    check("t1_iso_off", isolate, 0);
    check("t1_rcnt", rcnt, 1);
    check("t1_cause_hold", cause, 1);

    // Isolation timeout: isolated_i stuck low
    wr_req = 1'b1;
    step();
    wr_req = 1'b0;
    n = 0;
    while (slv_rst_n == 1'b1 && n < 50) begin
      n++;
      step();
    end
    check("t2_isolate_cycles", n, IT);
    check("t2_timeout", timeout, 1);
    count_reset(n, seen);
    check("t2_rst_cycles", n, RC);
    sw_clr = 1'b1; step(); sw_clr = 1'b0; step();
    check("t2_timeout_held", timeout, 1);
    check("t2_rcnt", rcnt, 2);

    // Read request arrives during RESET of a write episode
    wr_req = 1'b1;
    step();
    wr_req = 1'b0;
    check("t3_timeout_cleared", timeout, 0);
    check("t3_cause_init", cause, 1);
    iso_in = 1'b1;
    step();
    iso_in = 1'b0;
    n = 0;
    seen = 1'b0;
    while (slv_rst_n == 1'b0 && n < 50) begin
      seen |= irq;
      if (n == 1) rd_req = 1'b1;
      if (n == 2) rd_req = 1'b0;
      n++;
      step();
    end
    check("t3_rst_cycles", n, RC);
    check("t3_no_restart", seen, 0);
    check("t3_cause", cause, 3);
    sw_clr = 1'b1; step(); sw_clr = 1'b0; step();
    check("t3_rcnt", rcnt, 3);

    // Clear pulsed in ISOLATE and in RESET
    wr_req = 1'b1;
    step();
    wr_req = 1'b0;
    sw_clr = 1'b1;
    step();
    sw_clr = 1'b0;
    check("t4_iso_clear_ignored", reset_clear, 0);
    check("t4_iso_busy", busy, 1);
    iso_in = 1'b1;
    step();
    iso_in = 1'b0;
    sw_clr = 1'b1;
    step();
    sw_clr = 1'b0;
    check("t4_rst_clear_ignored", reset_clear, 0);
    check("t4_rst_low", slv_rst_n, 0);
    count_reset(n, seen);
    check("t4_rst_cycles", n, RC - 1);
`ifdef GUARD_RECOVERY_AUTO_CLEAR_EN
    check("t4_hold_no_clear", reset_clear, 0);
    step();
    check("t4_auto_clear", reset_clear, 1);
    step();
`else
    for (int i = 0; i < 3; i++) begin
      check("t4_hold_wait_busy", busy, 1);
      check("t4_hold_wait_clear", reset_clear, 0);
      step();
    end
    sw_clr = 1'b1;
    step();
    sw_clr = 1'b0;
    check("t4_late_clear", reset_clear, 1);
    step();
`endif
    check("t4_busy_off", busy, 0);
    check("t4_rcnt", rcnt, 4);

    // isolated_i and timeout on the same cycle
    wr_req = 1'b1;
    step();
    wr_req = 1'b0;
    for (int i = 0; i < 7; i++) step();
    check("t5_still_isolating", slv_rst_n, 1);
    iso_in = 1'b1;
    step();
    iso_in = 1'b0;
    check("t5_rst_low", slv_rst_n, 0);
    check("t5_no_timeout", timeout, 0);

    // Synchronous reset while in RESET
    rst_n = 1'b0;
    step();
    check_reset_values("t6");
    rst_n = 1'b1;
    step();
    check("t6_idle", busy, 0);

    // Persistent request: back-to-back episodes, counter saturation
    wr_req = 1'b1;
    iso_in = 1'b1;
    step();
    check("t7_first_irq", irq, 1);
    for (int e = 1; e <= 260; e++) begin
      step();
      count_reset(n, seen);
      if (e == 1) check("t7_rst_cycles", n, RC);
      sw_clr = 1'b1;
      step();
      sw_clr = 1'b0;
      if (e == 1) check("t7_clear", reset_clear, 1);
      step();
      if (e == 1) begin
        check("t7_idle_busy", busy, 0);
        check("t7_idle_irq", irq, 0);
        check("t7_rcnt1", rcnt, 1);
      end
      if (e == 254) check("t7_rcnt254", rcnt, 254);
      if (e == 255) check("t7_rcnt255", rcnt, 255);
      if (e < 260) begin
        step();
        if (e == 1) check("t7_restart_irq", irq, 1);
      end
    end
    check("t7_rcnt_sat", rcnt, 255);
    wr_req = 1'b0;
    iso_in = 1'b0;
    step();
    check("t7_stays_idle", busy, 0);
    check("t7_no_irq", irq, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
